// File: rtl/ooo_pkg.sv
// Out-of-order core constants that the rename and register-file blocks share.
package ooo_pkg;

    localparam int unsigned PHYS_REGS           = 128;
    localparam int unsigned ARCH_REGS           = 32;
    localparam int unsigned REG_FILE_ADDR_WIDTH = $clog2(PHYS_REGS);

endpackage

// File: rtl/phys_reg_free_list_circ_ptr_add.sv
// Adds the popcount of a request vector to a circular pointer, wrapping modulo DEPTH.
// DEPTH does not have to be a power of two.
module circ_ptr_add #(
    parameter int unsigned DEPTH = 96,
    parameter int unsigned PTR_W = 7,
    parameter int unsigned VEC_W = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [VEC_W-1:0] vec,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [PTR_W-1:0] ptr_nxt
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] sum;

    // cnt is the raw popcount; ptr_nxt advances only when en is set
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        sum = {1'b0, ptr} + SUM_W'(cnt);
        if (sum >= SUM_W'(DEPTH)) begin
            sum = sum - SUM_W'(DEPTH);
        end
        ptr_nxt = en ? sum[PTR_W-1:0] : ptr;
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list with speculative allocation, commit, and flush recovery.
// Layout of the circular array: [commit_head, spec_head) holds outstanding allocations,
// and [spec_head, tail) holds free registers.
module phys_reg_free_list #(
    parameter int unsigned PHYS_REGS = ooo_pkg::PHYS_REGS,
    parameter int unsigned ARCH_REGS = ooo_pkg::ARCH_REGS,
    parameter int unsigned ALLOC_W   = 2,
    parameter int unsigned FREE_W    = 2,
    localparam int unsigned ADDR_W   = $clog2(PHYS_REGS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ALLOC_W-1:0]             alloc_req,
    output logic                           alloc_ready,
    output logic [ALLOC_W-1:0][ADDR_W-1:0] alloc_reg,
    input  logic [ALLOC_W-1:0]             commit_valid,
    input  logic [FREE_W-1:0]              free_valid,
    input  logic [FREE_W-1:0][ADDR_W-1:0]  free_reg,
    input  logic                           flush,
    output logic [ADDR_W:0]                free_count,
    output logic                           empty,
    output logic                           overflow_err,
    output logic                           underflow_err
);

    localparam int unsigned DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned AC_W  = $clog2(ALLOC_W + 1);
    localparam int unsigned FC_W  = $clog2(FREE_W + 1);

    logic [ADDR_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0]  spec_head_q, commit_head_q, tail_q;
    logic [CNT_W-1:0]  spec_count_q, out_count_q;

    logic              alloc_contig, alloc_fire, commit_ok, free_ok;
    logic [AC_W-1:0]   n_alloc, n_commit;
    logic [FC_W-1:0]   n_free, free_acc;
    logic [FC_W-1:0]   free_off [FREE_W];
    logic [PTR_W-1:0]  spec_head_adv, commit_head_nxt, tail_nxt, spec_head_nxt;
    logic [CNT_W-1:0]  n_a, n_c, n_f, spec_count_nxt, out_count_nxt;
    logic [CNT_W:0]    committed;

    function automatic logic [PTR_W-1:0] ptr_off(input logic [PTR_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return PTR_W'(s);
    endfunction

    circ_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W), .VEC_W(ALLOC_W), .CNT_W(AC_W)) u_spec_add (
        .ptr(spec_head_q), .vec(alloc_req), .en(alloc_fire), .cnt(n_alloc), .ptr_nxt(spec_head_adv)
    );

    circ_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W), .VEC_W(ALLOC_W), .CNT_W(AC_W)) u_commit_add (
        .ptr(commit_head_q), .vec(commit_valid), .en(commit_ok), .cnt(n_commit), .ptr_nxt(commit_head_nxt)
    );

    circ_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W), .VEC_W(FREE_W), .CNT_W(FC_W)) u_tail_add (
        .ptr(tail_q), .vec(free_valid), .en(free_ok), .cnt(n_free), .ptr_nxt(tail_nxt)
    );

    // Offered registers come straight from the array; no flop in the path
    always_comb begin
        for (int unsigned i = 0; i < ALLOC_W; i++) begin
            alloc_reg[i] = entry_q[ptr_off(spec_head_q, i)];
        end
    end

    // Each valid free slot writes at the tail offset given by the valid slots below it
    always_comb begin
        free_acc = '0;
        for (int unsigned j = 0; j < FREE_W; j++) begin
            free_off[j] = free_acc;
            free_acc    = free_acc + FC_W'(free_valid[j]);
        end
    end

    always_comb begin
        alloc_contig = ((alloc_req & (alloc_req + ALLOC_W'(1))) == '0);
        alloc_fire   = alloc_ready && !flush && alloc_contig;
        commit_ok    = (CNT_W'(n_commit) <= out_count_q);
        committed    = {1'b0, spec_count_q} + {1'b0, out_count_q};
        free_ok      = ((committed + (CNT_W+1)'(n_free)) <= (CNT_W+1)'(DEPTH));

        n_a = alloc_fire ? CNT_W'(n_alloc) : '0;
        n_c = commit_ok  ? CNT_W'(n_commit) : '0;
        n_f = free_ok    ? CNT_W'(n_free) : '0;

        // A flush returns every uncommitted allocation to the free region
        if (flush) begin
            spec_head_nxt  = commit_head_nxt;
            spec_count_nxt = spec_count_q + out_count_q - n_c + n_f;
            out_count_nxt  = '0;
        end else begin
            spec_head_nxt  = spec_head_adv;
            spec_count_nxt = spec_count_q - n_a + n_f;
            out_count_nxt  = out_count_q + n_a - n_c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= ADDR_W'(ARCH_REGS + i);
            end
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= '0;
            spec_count_q  <= CNT_W'(DEPTH);
            out_count_q   <= '0;
            alloc_ready   <= (DEPTH >= ALLOC_W);
            empty         <= (DEPTH == 0);
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < FREE_W; j++) begin
                if (free_ok && free_valid[j]) begin
                    entry_q[ptr_off(tail_q, 32'(free_off[j]))] <= free_reg[j];
                end
            end
            spec_head_q   <= spec_head_nxt;
            commit_head_q <= commit_head_nxt;
            tail_q        <= tail_nxt;
            spec_count_q  <= spec_count_nxt;
            out_count_q   <= out_count_nxt;
            alloc_ready   <= (spec_count_nxt >= CNT_W'(ALLOC_W));
            empty         <= (spec_count_nxt == '0);
            overflow_err  <= overflow_err | !free_ok;
            underflow_err <= underflow_err | !commit_ok;
        end
    end

    assign free_count = spec_count_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list, using a queue-based reference free list.
module tb_phys_reg_free_list;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       alloc_req;
    logic             alloc_ready;
    logic [1:0][6:0]  alloc_reg;
    logic [1:0]       commit_valid;
    logic [1:0]       free_valid;
    logic [1:0][6:0]  free_reg;
    logic             flush;
    logic [7:0]       free_count;
    logic             empty;
    logic             overflow_err;
    logic             underflow_err;

    int total = 0;
    int bad   = 0;

    int free_q[$];
    int out_q[$];
    int exp_q[$];
    int got_q[$];
    bit m_ovf, m_unf;

    phys_reg_free_list dut (
        .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
        .alloc_reg(alloc_reg), .commit_valid(commit_valid), .free_valid(free_valid),
        .free_reg(free_reg), .flush(flush), .free_count(free_count), .empty(empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic set_idle();
        alloc_req = 2'b00; commit_valid = 2'b00; free_valid = 2'b00;
        free_reg[0] = 7'd0; free_reg[1] = 7'd0; flush = 1'b0;
    endtask

    task automatic model_reset();
        free_q.delete(); out_q.delete(); exp_q.delete(); got_q.delete();
        for (int i = 0; i < 96; i++) free_q.push_back(32 + i);
        m_ovf = 0; m_unf = 0;
    endtask

    // Reset while driving busy inputs; all of them must be dropped
    task automatic do_reset();
        reset = 1'b1;
        alloc_req = 2'b11; commit_valid = 2'b11; free_valid = 2'b11;
        free_reg[0] = 7'd3; free_reg[1] = 7'd4; flush = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        set_idle();
        model_reset();
    endtask

    // One clock of stimulus: capture offered registers, push expectations, advance the model
    task automatic drive(input logic [1:0] a, input logic [1:0] c, input logic [1:0] fv,
                         input int r0, input int r1, input logic fl);
        int n_a, n_c, n_f;
        bit fire;
        alloc_req = a; commit_valid = c; free_valid = fv;
        free_reg[0] = 7'(r0); free_reg[1] = 7'(r1); flush = fl;
        #1;
        fire = (free_q.size() >= 2) && !fl && (a != 2'b10);
        n_a  = fire ? $countones(a) : 0;
        for (int i = 0; i < n_a; i++) begin
            exp_q.push_back(free_q[i]);
            got_q.push_back(int'(alloc_reg[i]));
        end
        n_c = $countones(c);
        if (n_c > out_q.size()) begin m_unf = 1; n_c = 0; end
        n_f = $countones(fv);
        if (free_q.size() + out_q.size() + n_f > 96) begin m_ovf = 1; n_f = 0; end
        @(posedge clock); #1;
        set_idle();
        for (int i = 0; i < n_a; i++) out_q.push_back(free_q.pop_front());
        for (int i = 0; i < n_c; i++) void'(out_q.pop_front());
        if (n_f > 0) begin
            if (fv[0]) free_q.push_back(r0);
            if (fv[1]) free_q.push_back(r1);
        end
        if (fl) while (out_q.size() > 0) free_q.push_front(out_q.pop_back());
    endtask

    task automatic test_reset();
        int e, g;
        do_reset();
        total++; if (free_count !== 8'd96) begin bad++; $display("FAIL reset_free_count got=%0d exp=96", free_count); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL reset_empty got=%0b exp=0", empty); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
        total++; if ({overflow_err, underflow_err} !== 2'b00) begin bad++; $display("FAIL reset_errs got=%b exp=00", {overflow_err, underflow_err}); end
        total++; if (alloc_reg[0] !== 7'd32 || alloc_reg[1] !== 7'd33) begin bad++; $display("FAIL reset_alloc_reg got=%0d,%0d exp=32,33", alloc_reg[0], alloc_reg[1]); end
    endtask

    task automatic test_basic_alloc();
        int e, g;
        do_reset();
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        total++; if (free_count !== 8'd94) begin bad++; $display("FAIL basic_count1 got=%0d exp=94", free_count); end
        total++; if (alloc_reg[0] !== 7'd34 || alloc_reg[1] !== 7'd35) begin bad++; $display("FAIL basic_alloc_reg2 got=%0d,%0d exp=34,35", alloc_reg[0], alloc_reg[1]); end
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        total++; if (free_count !== 8'd92) begin bad++; $display("FAIL basic_count2 got=%0d exp=92", free_count); end
        drive(2'b10, 2'b00, 2'b00, 0, 0, 0);
        total++; if (free_count !== 8'd92 || alloc_reg[0] !== 7'd36) begin bad++; $display("FAIL noncontig_ignored got=%0d,%0d exp=92,36", free_count, alloc_reg[0]); end
        drive(2'b01, 2'b00, 2'b00, 0, 0, 0);
        total++; if (free_count !== 8'(free_q.size())) begin bad++; $display("FAIL single_alloc_count got=%0d exp=%0d", free_count, free_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL basic_sb got=%0d exp=%0d", g, e); end
        end
    endtask

    task automatic test_empty_refill();
        int e, g;
        do_reset();
        for (int k = 0; k < 48; k++) drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        total++; if (empty !== 1'b1 || alloc_ready !== 1'b0 || free_count !== 8'd0) begin
            bad++; $display("FAIL drained got=e%0b r%0b c%0d exp=e1 r0 c0", empty, alloc_ready, free_count); end
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        total++; if (free_count !== 8'd0) begin bad++; $display("FAIL hold_not_ready got=%0d exp=0", free_count); end
        for (int k = 0; k < 48; k++) drive(2'b00, 2'b11, 2'b00, 0, 0, 0);
        drive(2'b11, 2'b00, 2'b11, 5, 6, 0);
        total++; if (free_count !== 8'd2 || alloc_ready !== 1'b1 || empty !== 1'b0) begin
            bad++; $display("FAIL refill_state got=c%0d r%0b e%0b exp=c2 r1 e0", free_count, alloc_ready, empty); end
        total++; if (alloc_reg[0] !== 7'd5 || alloc_reg[1] !== 7'd6) begin bad++; $display("FAIL refill_alloc_reg got=%0d,%0d exp=5,6", alloc_reg[0], alloc_reg[1]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL drain_sb got=%0d exp=%0d", g, e); end
        end
    endtask

    task automatic test_flush();
        int e, g;
        do_reset();
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        drive(2'b00, 2'b11, 2'b00, 0, 0, 0);
        drive(2'b11, 2'b00, 2'b00, 0, 0, 1);
        total++; if (free_count !== 8'd94) begin bad++; $display("FAIL flush_count got=%0d exp=94", free_count); end
        total++; if (alloc_reg[0] !== 7'd34 || alloc_reg[1] !== 7'd35) begin bad++; $display("FAIL flush_alloc_reg got=%0d,%0d exp=34,35", alloc_reg[0], alloc_reg[1]); end
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL flush_sb got=%0d exp=%0d", g, e); end
        end
    endtask

    task automatic test_wrap();
        int e, g;
        do_reset();
        drive(2'b01, 2'b00, 2'b00, 0, 0, 0);
        for (int k = 0; k < 47; k++) drive(2'b11, (k == 0) ? 2'b01 : 2'b11, 2'b00, 0, 0, 0);
        drive(2'b00, 2'b11, 2'b00, 0, 0, 0);
        total++; if (free_count !== 8'd1 || alloc_ready !== 1'b0) begin bad++; $display("FAIL wrap_pre got=c%0d r%0b exp=c1 r0", free_count, alloc_ready); end
        for (int k = 0; k < 47; k++) drive(2'b00, 2'b00, 2'b11, 2 * k + 1, 2 * k + 2, 0);
        total++; if (free_count !== 8'd95) begin bad++; $display("FAIL wrap_refill got=%0d exp=95", free_count); end
        total++; if (alloc_reg[0] !== 7'd127 || alloc_reg[1] !== 7'd1) begin bad++; $display("FAIL wrap_alloc_reg got=%0d,%0d exp=127,1", alloc_reg[0], alloc_reg[1]); end
        for (int k = 0; k < 3; k++) drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        total++; if (free_count !== 8'd89) begin bad++; $display("FAIL wrap_count got=%0d exp=89", free_count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL wrap_sb got=%0d exp=%0d", g, e); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(2'b00, 2'b00, 2'b01, 9, 0, 0);
        total++; if (overflow_err !== 1'b1 || free_count !== 8'd96) begin bad++; $display("FAIL overflow got=o%0b c%0d exp=o1 c96", overflow_err, free_count); end
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0);
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0);
        total++; if (overflow_err !== 1'b1 || underflow_err !== 1'b0) begin bad++; $display("FAIL overflow_sticky got=o%0b u%0b exp=o1 u0", overflow_err, underflow_err); end
        total++; if (alloc_reg[0] !== 7'd32) begin bad++; $display("FAIL overflow_no_write got=%0d exp=32", alloc_reg[0]); end
    endtask

    task automatic test_underflow();
        int e, g;
        do_reset();
        drive(2'b00, 2'b01, 2'b00, 0, 0, 0);
        total++; if (underflow_err !== 1'b1 || free_count !== 8'd96) begin bad++; $display("FAIL underflow got=u%0b c%0d exp=u1 c96", underflow_err, free_count); end
        total++; if (alloc_reg[0] !== 7'd32 || alloc_reg[1] !== 7'd33) begin bad++; $display("FAIL underflow_ptrs got=%0d,%0d exp=32,33", alloc_reg[0], alloc_reg[1]); end
        do_reset();
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        drive(2'b00, 2'b01, 2'b00, 0, 0, 1);
        total++; if (free_count !== 8'd95 || underflow_err !== 1'b0) begin bad++; $display("FAIL flush_commit got=c%0d u%0b exp=c95 u0", free_count, underflow_err); end
        total++; if (alloc_reg[0] !== 7'd33 || alloc_reg[1] !== 7'd34) begin bad++; $display("FAIL flush_commit_reg got=%0d,%0d exp=33,34", alloc_reg[0], alloc_reg[1]); end
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL underflow_sb got=%0d exp=%0d", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        int e, g;
        do_reset();
        drive(2'b11, 2'b00, 2'b00, 0, 0, 0);
        drive(2'b11, 2'b11, 2'b00, 0, 0, 0);
        drive(2'b11, 2'b11, 2'b11, 3, 4, 0);
        total++; if (free_count !== 8'd92) begin bad++; $display("FAIL simul_count got=%0d exp=92", free_count); end
        for (int k = 0; k < 20; k++)
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 127), $urandom_range(0, 127), ($urandom_range(0, 7) == 0));
        total++; if (free_count !== 8'(free_q.size())) begin bad++; $display("FAIL random_count got=%0d exp=%0d", free_count, free_q.size()); end
        total++; if (overflow_err !== m_ovf || underflow_err !== m_unf) begin bad++; $display("FAIL random_errs got=o%0b u%0b exp=o%0b u%0b", overflow_err, underflow_err, m_ovf, m_unf); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL b2b_sb got=%0d exp=%0d", g, e); end
        end
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        test_reset();
        test_basic_alloc();
        test_empty_refill();
        test_flush();
        test_wrap();
        test_overflow();
        test_underflow();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
